// File: rtl/cpu_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// The divide path is built only when MULDIV_DIV_EN is defined.
package cpu_muldiv_pkg;

  localparam int unsigned WIDTH      = 24;
  localparam logic [2:0]  ALU_OP_ADD = 3'b010;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    NEG,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider that borrows the shared CPU ALU.
// Define MULDIV_DIV_EN to build the divide path (NEG/DIV states, DivByZero).
module alu_muldiv_seq #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned CNT_W      = 5,
  parameter logic [2:0]  ALU_OP_ADD = 3'b010
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultHi,
  output logic [WIDTH-1:0] ResultLo,
  output logic             DivByZero,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic             AluAInvert,
  output logic             AluBNegate,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut
);
  import cpu_muldiv_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  // hi/lo hold {P_hi, P_lo} while multiplying and {R, Q} while dividing.
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   m_q;
  logic               dbz_q;
  logic               last;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   negd_q;
  logic [WIDTH-1:0]   div_s;
  logic               take;

  assign div_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  // A set R msb means the shifted remainder is at least 2^WIDTH, so D always fits.
  assign take  = hi_q[WIDTH-1] | AluCarryOut;
`endif

  assign last       = (cnt_q == CNT_W'(WIDTH - 1));
  assign ResultHi   = hi_q;
  assign ResultLo   = lo_q;
  assign DivByZero  = dbz_q;
  assign AluAInvert = 1'b0;
  assign AluBNegate = 1'b0;
  assign AluOp      = ALU_OP_ADD;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (Op == OP_MUL) begin
            state_d = MUL;
          end
`ifdef MULDIV_DIV_EN
          else if (OpB != '0) begin
            state_d = NEG;
          end
`endif
          else begin
            state_d = DONE;
          end
        end
      end
      MUL: begin
        if (last) state_d = DONE;
      end
`ifdef MULDIV_DIV_EN
      NEG: state_d = DIV;
      DIV: begin
        if (last) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q != IDLE);
    Done = (state_q == DONE);
    AluA = '0;
    AluB = '0;
    unique case (state_q)
      MUL: begin
        AluA = hi_q;
        AluB = m_q;
      end
`ifdef MULDIV_DIV_EN
      NEG: begin
        AluA = ~m_q;
        AluB = WIDTH'(1);
      end
      DIV: begin
        AluA = div_s;
        AluB = negd_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      dbz_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      negd_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            cnt_q <= '0;
            dbz_q <= 1'b0;
            if (Op == OP_MUL) begin
              m_q  <= OpA;
              hi_q <= '0;
              lo_q <= OpB;
            end
`ifdef MULDIV_DIV_EN
            else if (OpB != '0) begin
              m_q  <= OpB;
              hi_q <= '0;
              lo_q <= OpA;
            end else begin
              hi_q  <= OpA;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end
`else
            else begin
              hi_q <= '0;
              lo_q <= '0;
            end
`endif
          end
        end
        MUL: begin
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          if (lo_q[0]) begin
            hi_q <= {AluCarryOut, AluResult[WIDTH-1:1]};
            lo_q <= {AluResult[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_q <= {1'b0, hi_q[WIDTH-1:1]};
            lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end
`ifdef MULDIV_DIV_EN
        NEG: begin
          negd_q <= AluResult;
          cnt_q  <= '0;
        end
        DIV: begin
          cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
          if (take) begin
            hi_q <= AluResult;
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= div_s;
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with an external 24-bit adder standing in for the CPU ALU.
// Expected results come from plain 48-bit multiply and integer divide/modulo.
module tb_alu_muldiv_seq;

  logic        Clock, Reset, Start, Op;
  logic [23:0] OpA, OpB, ResultHi, ResultLo, AluA, AluB, AluResult;
  logic        Busy, Done, DivByZero, AluAInvert, AluBNegate, AluCarryOut;
  logic [2:0]  AluOp;
  logic [23:0] alu_a, alu_b;
  logic [24:0] alu_sum;

  int n_cmp = 0;
  int n_bad = 0;

  alu_muldiv_seq dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OpA        (OpA),
    .OpB        (OpB),
    .Busy       (Busy),
    .Done       (Done),
    .ResultHi   (ResultHi),
    .ResultLo   (ResultLo),
    .DivByZero  (DivByZero),
    .AluA       (AluA),
    .AluB       (AluB),
    .AluAInvert (AluAInvert),
    .AluBNegate (AluBNegate),
    .AluOp      (AluOp),
    .AluResult  (AluResult),
    .AluCarryOut(AluCarryOut)
  );

  // Shared CPU ALU: add with optional A invert / B negate.
  always_comb begin
    alu_a   = AluAInvert ? ~AluA : AluA;
    alu_b   = AluBNegate ? ~AluB : AluB;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 25'(AluBNegate);
  end
  assign AluResult   = alu_sum[23:0];
  assign AluCarryOut = alu_sum[24];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that ends the Done cycle.
  task automatic run_op(input logic op, input logic [23:0] a, input logic [23:0] b,
                        input string tag);
    logic [47:0] prod;
    logic [23:0] e_hi, e_lo;
    logic        e_dbz;
    int          e_lat, got_lat;
    prod = 48'(a) * 48'(b);
    if (op == 1'b0) begin
      e_hi = prod[47:24]; e_lo = prod[23:0]; e_dbz = 1'b0; e_lat = 25;
    end
`ifdef MULDIV_DIV_EN
    else if (b == 24'd0) begin
      e_hi = a; e_lo = 24'hFFFFFF; e_dbz = 1'b1; e_lat = 1;
    end else begin
      e_hi = a % b; e_lo = a / b; e_dbz = 1'b0; e_lat = 26;
    end
`else
    else begin
      e_hi = 24'd0; e_lo = 24'd0; e_dbz = 1'b0; e_lat = 1;
    end
`endif
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clock); #1;
    Start = 1'b0; OpA = 24'($urandom); OpB = 24'($urandom);
    got_lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      check({tag, ":busy"}, 48'(Busy), 48'd1);
      if (Done) begin
        got_lat = k;
        break;
      end
    end
    check({tag, ":latency"}, 48'(got_lat), 48'(e_lat));
    check({tag, ":result"}, {ResultHi, ResultLo}, {e_hi, e_lo});
    check({tag, ":dbz"}, 48'(DivByZero), 48'(e_dbz));
    @(posedge Clock); #1;
    check({tag, ":idle_flags"}, {46'd0, Busy, Done}, 48'd0);
    check({tag, ":hold"}, {ResultHi, ResultLo}, {e_hi, e_lo});
    check({tag, ":idle_alu"}, {AluA, AluB}, 48'd0);
  endtask

  initial begin
    int got;
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    #7;
    check("reset_flags", {45'd0, Busy, Done, DivByZero}, 48'd0);
    check("reset_result", {ResultHi, ResultLo}, 48'd0);
    check("reset_alu", {AluA, AluB}, 48'd0);
    check("alu_ctrl", {43'd0, AluAInvert, AluBNegate, AluOp}, 48'h2);
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;

    run_op(1'b0, 24'd3, 24'd5, "mul_3x5");
    run_op(1'b0, 24'hFFFFFF, 24'hFFFFFF, "mul_max");
    run_op(1'b1, 24'd100, 24'd7, "div_100_7");
    run_op(1'b1, 24'hFFFFFF, 24'h800000, "div_rmsb");
    run_op(1'b1, 24'hFFFFFF, 24'h000001, "div_by_1");
    run_op(1'b1, 24'h0004D2, 24'h000000, "div_zero");
    run_op(1'b0, 24'd7, 24'd9, "mul_after_dbz");

    for (int i = 0; i < 24; i++) begin
      logic        op;
      logic [23:0] a, b;
      int          sel;
      op  = 1'($urandom_range(0, 1));
      a   = 24'($urandom);
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 24'd0 : (sel == 1) ? 24'($urandom_range(1, 15)) : 24'($urandom);
      run_op(op, a, b, $sformatf("rand%0d", i));
    end

    // Start pulsed while busy must be ignored.
    Start = 1'b1; Op = 1'b0; OpA = 24'd3; OpB = 24'd5;
    @(posedge Clock); #1; Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1; Start = 1'b1; Op = 1'b1; OpA = 24'h123456; OpB = 24'd0;
    @(posedge Clock); #1; Start = 1'b0;
    got = -1;
    for (int k = 6; k <= 40; k++) begin
      @(negedge Clock);
      if (Done) begin
        got = k;
        break;
      end
    end
    check("ignore:latency", 48'(got), 48'd25);
    check("ignore:result", {ResultHi, ResultLo}, 48'h00000F);
    check("ignore:dbz", 48'(DivByZero), 48'd0);
    @(posedge Clock); #1;

    // Asynchronous reset in MUL cycle 10.
    Start = 1'b1; Op = 1'b0; OpA = 24'd3; OpB = 24'd5;
    @(posedge Clock); #1; Start = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    check("mid_mul:alu_b", 48'(AluB), 48'd3);
    Reset = 1'b1; #1;
    check("async_reset:flags", {45'd0, Busy, Done, DivByZero}, 48'd0);
    check("async_reset:result", {ResultHi, ResultLo}, 48'd0);
    check("async_reset:alu", {AluA, AluB}, 48'd0);
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    run_op(1'b0, 24'd3, 24'd5, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
